// File: rtl/fp_pkg.sv
// Shared definitions for the float_adder normalise/round stage: field widths,
// sum field positions and the FSM state encoding.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SUM_W = MAN_W + 5;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Bit positions inside the signed-magnitude sum from the significand adder
    localparam int SUM_SIGN   = SUM_W - 1;
    localparam int SUM_CARRY  = SUM_W - 2;
    localparam int SUM_HIDDEN = SUM_W - 3;
    localparam int SUM_GUARD  = 1;
    localparam int SUM_STICKY = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even and IEEE-754 single encoding of a normalised magnitude.
// mag[25]=hidden, mag[24:2]=mantissa, mag[1]=guard, mag[0]=sticky.
// A clear hidden bit means the value is denormal (exponent is 1 at that point).
module fp_round_rne
    import fp_pkg::*;
(
    input  logic                 sign,
    input  logic [EXP_W:0]       exp,
    input  logic [MAN_W+2:0]     mag,
    output logic [EXP_W+MAN_W:0] word,
    output logic                 ovf
);

    logic               lsb;
    logic               grd;
    logic               stk;
    logic               round_up;
    logic [MAN_W+1:0]   sig_rnd;
    logic [MAN_W-1:0]   man_f;
    logic [EXP_W:0]     exp_f;

    // Round the 24-bit significand, then fix up exponent for carry or denormal promotion
    always_comb begin
        lsb      = mag[2];
        grd      = mag[SUM_GUARD];
        stk      = mag[SUM_STICKY];
        round_up = grd & (stk | lsb);
        sig_rnd  = {1'b0, mag[MAN_W+2:2]} + {{(MAN_W+1){1'b0}}, round_up};

        if (sig_rnd[MAN_W+1]) begin
            // rounding overflowed the hidden bit: renormalise by one
            man_f = sig_rnd[MAN_W:1];
            exp_f = exp + 1'b1;
        end else if (!mag[MAN_W+2]) begin
            // denormal: exponent field is 0 unless rounding reached the hidden bit
            man_f = sig_rnd[MAN_W-1:0];
            exp_f = sig_rnd[MAN_W] ? {{EXP_W{1'b0}}, 1'b1} : '0;
        end else begin
            man_f = sig_rnd[MAN_W-1:0];
            exp_f = exp;
        end

        if (exp_f >= {1'b0, EXP_MAX}) begin
            word = {sign, EXP_MAX, {MAN_W{1'b0}}};
            ovf  = 1'b1;
        end else begin
            word = {sign, exp_f[EXP_W-1:0], man_f};
            ovf  = 1'b0;
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Final float_adder stage: normalises the signed-magnitude sum one bit per
// cycle, rounds to nearest-even and presents an IEEE-754 single word with a
// valid/ready handshake on both sides.
module fp_norm_round
    import fp_pkg::*;
(
    input  logic                 clk,
    input  logic                 res,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SUM_W-1:0]     sum,
    input  logic [EXP_W-1:0]     exp_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_data,
    output logic                 ovf,
    output logic                 zero
);

    state_e                 state_q, state_d;
    logic [SUM_W-2:0]       mag_q, mag_d;
    logic [EXP_W:0]         exp_q, exp_d;
    logic                   sgn_q, sgn_d;
    logic                   zres_q, zres_d;
    logic                   out_valid_q, out_valid_d;
    logic [EXP_W+MAN_W:0]   out_data_q, out_data_d;
    logic                   ovf_q, ovf_d;
    logic                   zero_q, zero_d;

    logic [EXP_W+MAN_W:0]   rnd_word;
    logic                   rnd_ovf;

    fp_round_rne u_round (
        .sign (sgn_q),
        .exp  (exp_q),
        .mag  (mag_q[SUM_W-3:0]),
        .word (rnd_word),
        .ovf  (rnd_ovf)
    );

    // Ready only in IDLE and never while reset is held
    assign in_ready  = res && (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Next-state and datapath: one normalise action per NORM cycle
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        sgn_d       = sgn_q;
        zres_d      = zres_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mag_d   = sum[SUM_W-2:0];
                    sgn_d   = sum[SUM_SIGN];
                    // exponent 0 from the align stage is handled as 1
                    exp_d   = (exp_in == '0) ? {{EXP_W{1'b0}}, 1'b1} : {1'b0, exp_in};
                    zres_d  = 1'b0;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (mag_q == '0) begin
                    zres_d  = 1'b1;
                    state_d = ST_ROUND;
                end else if (mag_q[SUM_CARRY]) begin
                    // carry: shift right, folding the dropped bit into sticky
                    mag_d = {1'b0, mag_q[SUM_W-2:2], mag_q[1] | mag_q[0]};
                    exp_d = exp_q + 1'b1;
                end else if (!mag_q[SUM_HIDDEN] && (exp_q > {{EXP_W{1'b0}}, 1'b1})) begin
                    mag_d = {mag_q[SUM_W-3:0], 1'b0};
                    exp_d = exp_q - 1'b1;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (zres_q) begin
                    // cancellation always yields +0
                    out_data_d = '0;
                    ovf_d      = 1'b0;
                    zero_d     = 1'b1;
                end else begin
                    out_data_d = rnd_word;
                    ovf_d      = rnd_ovf;
                    zero_d     = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ovf_d       = 1'b0;
                    zero_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= ST_IDLE;
            mag_q       <= '0;
            exp_q       <= '0;
            sgn_q       <= 1'b0;
            zres_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            sgn_q       <= sgn_d;
            zres_q      <= zres_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: table of sums with hand-computed words,
// flags and latencies, plus back-pressure and mid-operation reset sequences.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] sum = '0;
    logic [7:0]  exp_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;

    fp_norm_round dut (
        .clk       (clk),
        .res       (res),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] sum;
        logic [7:0]  exp;
        logic [31:0] data;
        logic        ovf;
        logic        zero;
        int          lat;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Accept one sum at the next edge; returns the number of edges until out_valid
    task automatic issue(input logic [27:0] s, input logic [7:0] e, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        sum      = s;
        exp_in   = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        if (!out_valid) begin
            errors++;
            $display("FAIL out_valid_timeout actual=0 required=1");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_handshake", {31'b0, out_valid}, 32'd0);
        chk("ovf_after_handshake", {31'b0, ovf}, 32'd0);
        chk("zero_after_handshake", {31'b0, zero}, 32'd0);
        chk("in_ready_after_handshake", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic seen;

        vecs[0]  = '{28'h2000000, 8'd127, 32'h3F800000, 1'b0, 1'b0, 2};
        vecs[1]  = '{28'h4000000, 8'd127, 32'h40000000, 1'b0, 1'b0, 3};
        vecs[2]  = '{28'h4000000, 8'd254, 32'h7F800000, 1'b1, 1'b0, 3};
        vecs[3]  = '{28'h0800000, 8'd127, 32'h3E800000, 1'b0, 1'b0, 4};
        vecs[4]  = '{28'h2000006, 8'd127, 32'h3F800002, 1'b0, 1'b0, 2};
        vecs[5]  = '{28'h2000002, 8'd127, 32'h3F800000, 1'b0, 1'b0, 2};
        vecs[6]  = '{28'h3FFFFFE, 8'd127, 32'h40000000, 1'b0, 1'b0, 2};
        vecs[7]  = '{28'h8000000, 8'd127, 32'h00000000, 1'b0, 1'b1, 2};
        vecs[8]  = '{28'h0000004, 8'd1,   32'h00000001, 1'b0, 1'b0, 2};
        vecs[9]  = '{28'hA000000, 8'd127, 32'hBF800000, 1'b0, 1'b0, 2};
        vecs[10] = '{28'h1FFFFFE, 8'd1,   32'h00800000, 1'b0, 1'b0, 2};
        vecs[11] = '{28'h0000004, 8'd0,   32'h00000001, 1'b0, 1'b0, 2};
        vecs[12] = '{28'h0000004, 8'd3,   32'h00000004, 1'b0, 1'b0, 4};
        vecs[13] = '{28'h3FFFFFE, 8'd254, 32'h7F800000, 1'b1, 1'b0, 2};
        vecs[14] = '{28'h0000001, 8'd127, 32'h33000000, 1'b0, 1'b0, 27};
        vecs[15] = '{28'h4000006, 8'd127, 32'h40000001, 1'b0, 1'b0, 3};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

        // Table of directed vectors
        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].sum, vecs[i].exp, lat);
            $display("vec %0d sum=%h exp=%0d data=%h ovf=%0d zero=%0d lat=%0d",
                     i, vecs[i].sum, vecs[i].exp, out_data, ovf, zero, lat);
            chk($sformatf("data_%0d", i), out_data, vecs[i].data);
            chk($sformatf("ovf_%0d", i), {31'b0, ovf}, {31'b0, vecs[i].ovf});
            chk($sformatf("zero_%0d", i), {31'b0, zero}, {31'b0, vecs[i].zero});
            chk($sformatf("lat_%0d", i), lat, vecs[i].lat);
            drain();
        end

        // Back-pressure: result held for 5 cycles, no new input taken
        issue(28'h2000006, 8'd127, lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            sum      = 28'h4000000;
            chk("hold_out_data", out_data, 32'h3F800002);
            chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        $display("hold sequence data=%h", out_data);
        chk("hold_final_data", out_data, 32'h3F800002);
        drain();

        // Reset during a long NORM: job dropped, no output afterwards
        @(negedge clk);
        sum      = 28'h0000001;
        exp_in   = 8'd127;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        res = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready_release", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        $display("mid-NORM reset sequence out_valid_seen=%0d", seen);
        chk("midrst_no_output", {31'b0, seen}, 32'd0);

        // Stage still works after the aborted job
        issue(28'h2000000, 8'd127, lat);
        $display("post-reset vec data=%h lat=%0d", out_data, lat);
        chk("post_rst_data", out_data, 32'h3F800000);
        chk("post_rst_lat", lat, 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
